frac_lutk_cfg_shadow: RTL and testbench

- Parametrised successor to the fixed 6-input fracturable LUT tile.
- Generalises the LUT to K inputs and integrates the configuration chain memory.
- Adds a shadow/active register pair so a new truth table can be shifted in while the LUT keeps evaluating the old one. The new table takes effect only on a validated commit.
- Sits in the CLB physical fle, on the tile's ccff daisy chain.

---
 rtl/frac_lutk_cfg_shadow.sv | 155 +++++++++++++++
 tb/tb_frac_lutk_cfg_shadow.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_lutk_cfg_shadow.sv
// K-input fracturable LUT with integrated ccff chain and a shadow/active configuration pair.
// Optional: define FRAC_LUTK_CFG_PARITY_EN to prepend an even-parity bit checked at commit.
module frac_lutk_cfg_shadow #(
  parameter int K = 6
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         ccff_head,
  input  logic         cfg_en,
  input  logic         cfg_commit,
  input  logic [K-1:0] lut_in,
  output logic         ccff_tail,
  output logic         lut_out,
  output logic [1:0]   lut_frac_out,
  output logic         cfg_full,
  output logic         cfg_err,
  output logic         cfg_parity_err
);

  localparam int TBL = 1 << K;
  localparam int N   = TBL + 1;
`ifdef FRAC_LUTK_CFG_PARITY_EN
  localparam int L   = N + 1;
`else
  localparam int L   = N;
`endif
  localparam int CW  = $clog2(L + 1);
  localparam logic [CW-1:0] L_CNT  = CW'(L);
  localparam logic [CW-1:0] L_LAST = CW'(L - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [L-1:0]    shadow_r;
  logic [TBL-1:0]  sram_r;
  logic            mode_r;
  logic [CW-1:0]   cnt_r;
  logic            full_r, err_r, perr_r;
  logic            shift_s, accept_s, reject_s, par_fail_s, parity_ok_s;

`ifdef FRAC_LUTK_CFG_PARITY_EN
  // Whole chain (data plus parity bit) must XOR to zero for even parity.
  function automatic logic chain_parity_ok(input logic [L-1:0] chain);
    return ~(^chain);
  endfunction

  assign parity_ok_s = chain_parity_ok(shadow_r);
`else
  assign parity_ok_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; commit has priority over shift.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (shift_s) state_next_s = SHIFT;
        else         state_next_s = IDLE;
      end
      SHIFT: begin
        if (shift_s && (cnt_r == L_LAST)) state_next_s = FULL;
        else                              state_next_s = SHIFT;
      end
      FULL: begin
        if (accept_s) state_next_s = IDLE;
        else          state_next_s = FULL;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Per-cycle action decode: shift, accepted commit, rejected commit.
  always_comb begin
    shift_s    = 1'b0;
    accept_s   = 1'b0;
    reject_s   = 1'b0;
    par_fail_s = 1'b0;
    case (state_r)
      FULL: begin
        if (cfg_commit) begin
          if (parity_ok_s) begin
            accept_s = 1'b1;
          end else begin
            reject_s   = 1'b1;
            par_fail_s = 1'b1;
          end
        end else begin
          shift_s = cfg_en;
        end
      end
      IDLE, SHIFT: begin
        if (cfg_commit) reject_s = 1'b1;
        else            shift_s  = cfg_en;
      end
      default: begin
        reject_s = cfg_commit;
      end
    endcase
  end

  // Shadow chain, bit counter and active register.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow_r <= {L{1'b0}};
      cnt_r    <= {CW{1'b0}};
      sram_r   <= {TBL{1'b0}};
      mode_r   <= 1'b0;
    end else if (shift_s) begin
      shadow_r <= {shadow_r[L-2:0], ccff_head};
      if (cnt_r != L_CNT) cnt_r <= cnt_r + CNT_ONE;
    end else if (accept_s) begin
      cnt_r  <= {CW{1'b0}};
      sram_r <= shadow_r[TBL-1:0];
      mode_r <= shadow_r[N-1];
    end
  end

  // Registered status flags; error flags are sticky until reset.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      full_r <= 1'b0;
      err_r  <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      full_r <= (state_next_s == FULL);
      if (reject_s)   err_r  <= 1'b1;
      if (par_fail_s) perr_r <= 1'b1;
    end
  end

  assign ccff_tail      = shadow_r[L-1];
  assign cfg_full       = full_r;
  assign cfg_err        = err_r;
  assign cfg_parity_err = perr_r;

  // LUT evaluation is purely combinational from the active register.
  assign lut_out         = sram_r[lut_in];
  assign lut_frac_out[0] = mode_r & sram_r[{1'b0, lut_in[K-2:0]}];
  assign lut_frac_out[1] = mode_r & sram_r[{1'b1, lut_in[K-2:0]}];

endmodule

// File: tb/tb_frac_lutk_cfg_shadow.sv
// Self-checking bench for frac_lutk_cfg_shadow (K=6) against a queue-based reference model.
// Honours FRAC_LUTK_CFG_PARITY_EN when defined for the build.
module tb_frac_lutk_cfg_shadow;
  localparam int K   = 6;
  localparam int TBL = 1 << K;
  localparam int N   = TBL + 1;
`ifdef FRAC_LUTK_CFG_PARITY_EN
  localparam int L   = N + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int L   = N;
  localparam bit PAR = 1'b0;
`endif

  logic         prog_clk = 1'b0;
  logic         pReset = 1'b1, ccff_head = 1'b0, cfg_en = 1'b0, cfg_commit = 1'b0;
  logic [K-1:0] lut_in = '0;
  logic         ccff_tail, lut_out, cfg_full, cfg_err, cfg_parity_err;
  logic [1:0]   lut_frac_out;

  frac_lutk_cfg_shadow #(.K(K)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .ccff_head(ccff_head), .cfg_en(cfg_en),
    .cfg_commit(cfg_commit), .lut_in(lut_in), .ccff_tail(ccff_tail), .lut_out(lut_out),
    .lut_frac_out(lut_frac_out), .cfg_full(cfg_full), .cfg_err(cfg_err),
    .cfg_parity_err(cfg_parity_err)
  );

  always #5 prog_clk = ~prog_clk;

  int total = 0;
  int bad = 0;

  // Reference model: hist[0] is the most recently shifted bit.
  bit hist[$];
  int m_cnt;
  bit m_tbl[TBL];
  bit m_mode, m_err, m_perr;

  function automatic bit m_bit(int j);
    return (j < hist.size()) ? hist[j] : 1'b0;
  endfunction

  function automatic bit m_parity_ok();
    bit x = 1'b0;
    if (!PAR) return 1'b1;
    for (int j = 0; j < L; j++) x ^= m_bit(j);
    return (x == 1'b0);
  endfunction

  function automatic bit exp_lut(int idx);
    return m_tbl[idx];
  endfunction

  function automatic logic [1:0] exp_frac(int idx);
    int lo = idx % (TBL / 2);
    return m_mode ? {m_tbl[TBL / 2 + lo], m_tbl[lo]} : 2'b00;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    if (pReset) begin
      hist = {};
      m_cnt = 0;
      foreach (m_tbl[j]) m_tbl[j] = 1'b0;
      m_mode = 1'b0; m_err = 1'b0; m_perr = 1'b0;
    end else if (cfg_commit) begin
      if (m_cnt >= L && m_parity_ok()) begin
        for (int j = 0; j < TBL; j++) m_tbl[j] = m_bit(j);
        m_mode = m_bit(N - 1);
        m_cnt = 0;
      end else begin
        m_err = 1'b1;
        if (m_cnt >= L) m_perr = 1'b1;
      end
    end else if (cfg_en) begin
      hist.push_front(ccff_head);
      if (hist.size() > L) void'(hist.pop_back());
      if (m_cnt < L) m_cnt++;
    end
    #1;
  endtask

  task automatic shift_bit(input bit b);
    cfg_en = 1'b1; cfg_commit = 1'b0; ccff_head = b;
    tick();
    cfg_en = 1'b0;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1; cfg_en = 1'b0;
    tick();
    cfg_commit = 1'b0;
  endtask

  // Load order: [parity], mode, then table from highest index to lowest.
  task automatic build_seq(input bit mode, input bit tb[TBL], input bit bad_par, output bit seq[$]);
    bit p = mode;
    seq = {};
    for (int j = 0; j < TBL; j++) p ^= tb[j];
    if (PAR) seq.push_back(p ^ bad_par);
    seq.push_back(mode);
    for (int j = TBL - 1; j >= 0; j--) seq.push_back(tb[j]);
  endtask

  task automatic shift_word(input bit mode, input bit tb[TBL], input bit bad_par);
    bit seq[$];
    build_seq(mode, tb, bad_par, seq);
    foreach (seq[i]) shift_bit(seq[i]);
  endtask

  task automatic test_reset();
    pReset = 1'b1;
    tick(); tick();
    pReset = 1'b0;
    total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL reset_tail got=%b exp=0", ccff_tail); end
    total++; if (lut_out !== 1'b0) begin bad++; $display("FAIL reset_lut got=%b exp=0", lut_out); end
    total++; if (lut_frac_out !== 2'b00) begin bad++; $display("FAIL reset_frac got=%b exp=00", lut_frac_out); end
    total++; if (cfg_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", cfg_full); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    total++; if (cfg_parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", cfg_parity_err); end
  endtask

  task automatic test_and_table();
    bit t[TBL];
    for (int j = 0; j < TBL; j++) t[j] = ((j % 4) == 3);
    shift_word(1'b1, t, 1'b0);
    total++; if (cfg_full !== 1'b1) begin bad++; $display("FAIL and_full got=%b exp=1", cfg_full); end
    lut_in = 6'b000011;
    do_commit();
    total++; if (lut_out !== 1'b1) begin bad++; $display("FAIL and_lut_3 got=%b exp=1", lut_out); end
    total++; if (lut_frac_out !== 2'b11) begin bad++; $display("FAIL and_frac_3 got=%b exp=11", lut_frac_out); end
    total++; if (cfg_full !== 1'b0) begin bad++; $display("FAIL and_full_after got=%b exp=0", cfg_full); end
    lut_in = 6'b000010; #1;
    total++; if (lut_out !== 1'b0) begin bad++; $display("FAIL and_lut_2 got=%b exp=0", lut_out); end
    total++; if (lut_frac_out !== 2'b00) begin bad++; $display("FAIL and_frac_2 got=%b exp=00", lut_frac_out); end
    for (int i = 0; i < 16; i++) begin
      lut_in = K'($urandom); #1;
      total++; if (lut_out !== t[lut_in]) begin bad++; $display("FAIL and_sweep in=%0d got=%b exp=%b", lut_in, lut_out, t[lut_in]); end
    end
  endtask

  task automatic test_partial_commit();
    for (int i = 0; i < 40; i++) shift_bit(1'($urandom));
    do_commit();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL partial_err got=%b exp=1", cfg_err); end
    total++; if (cfg_full !== 1'b0) begin bad++; $display("FAIL partial_full got=%b exp=0", cfg_full); end
    for (int i = 0; i < 8; i++) begin
      lut_in = K'($urandom); #1;
      total++; if (lut_out !== exp_lut(lut_in)) begin bad++; $display("FAIL partial_lut in=%0d got=%b exp=%b", lut_in, lut_out, exp_lut(lut_in)); end
      total++; if (lut_frac_out !== exp_frac(lut_in)) begin bad++; $display("FAIL partial_frac in=%0d got=%b exp=%b", lut_in, lut_frac_out, exp_frac(lut_in)); end
    end
  endtask

  task automatic test_shadow_isolation();
    bit a[TBL], b[TBL];
    bit seq[$];
    bit bmode;
    foreach (a[j]) a[j] = 1'($urandom);
    foreach (b[j]) b[j] = 1'($urandom);
    bmode = 1'($urandom);
    // Fill the remainder of the partial load left by the previous test, then load A.
    while (m_cnt < L) shift_bit(1'b0);
    do_commit();
    shift_word(1'b1, a, 1'b0);
    do_commit();
    build_seq(bmode, b, 1'b0, seq);
    foreach (seq[i]) begin
      lut_in = K'($urandom);
      shift_bit(seq[i]);
      total++; if (lut_out !== a[lut_in]) begin bad++; $display("FAIL iso_hold in=%0d got=%b exp=%b", lut_in, lut_out, a[lut_in]); end
    end
    lut_in = K'($urandom);
    do_commit();
    total++; if (lut_out !== b[lut_in]) begin bad++; $display("FAIL iso_new in=%0d got=%b exp=%b", lut_in, lut_out, b[lut_in]); end
    total++; if (lut_frac_out !== exp_frac(lut_in)) begin bad++; $display("FAIL iso_frac in=%0d got=%b exp=%b", lut_in, lut_frac_out, exp_frac(lut_in)); end
  endtask

  task automatic test_commit_priority();
    bit c[TBL];
    bit x;
    foreach (c[j]) c[j] = 1'($urandom);
    c[TBL - 1] = 1'b0;
    x = 1'b1;
    for (int j = 1; j < TBL; j++) x ^= c[j];
    c[0] = x;  // whole table XOR mode is 0, so parity bit (if any) is 0
    shift_word(1'b1, c, 1'b0);
    lut_in = K'($urandom);
    cfg_en = 1'b1; cfg_commit = 1'b1; ccff_head = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_commit = 1'b0;
    total++; if (ccff_tail !== (PAR ? 1'b0 : 1'b1)) begin bad++; $display("FAIL prio_tail got=%b exp=%b", ccff_tail, PAR ? 1'b0 : 1'b1); end
    total++; if (cfg_full !== 1'b0) begin bad++; $display("FAIL prio_full got=%b exp=0", cfg_full); end
    total++; if (lut_out !== c[lut_in]) begin bad++; $display("FAIL prio_lut in=%0d got=%b exp=%b", lut_in, lut_out, c[lut_in]); end
  endtask

  task automatic test_overshift();
    bit first;
    first = 1'($urandom);
    for (int i = 0; i < L + 5; i++) begin
      shift_bit(i == 0 ? first : 1'($urandom));
      total++; if (cfg_full !== (i + 1 >= L)) begin bad++; $display("FAIL over_full n=%0d got=%b exp=%b", i + 1, cfg_full, (i + 1 >= L)); end
      if (i + 1 == L) begin
        total++; if (ccff_tail !== first) begin bad++; $display("FAIL over_tail_first got=%b exp=%b", ccff_tail, first); end
      end
      total++; if (ccff_tail !== m_bit(L - 1)) begin bad++; $display("FAIL over_tail n=%0d got=%b exp=%b", i + 1, ccff_tail, m_bit(L - 1)); end
    end
    do_commit();
    total++; if (cfg_full !== (m_cnt >= L)) begin bad++; $display("FAIL over_commit_full got=%b exp=%b", cfg_full, (m_cnt >= L)); end
    total++; if (cfg_err !== m_err) begin bad++; $display("FAIL over_commit_err got=%b exp=%b", cfg_err, m_err); end
  endtask

  task automatic test_parity();
`ifdef FRAC_LUTK_CFG_PARITY_EN
    bit g[TBL], h[TBL];
    pReset = 1'b1; tick(); pReset = 1'b0;
    foreach (g[j]) g[j] = 1'($urandom);
    foreach (h[j]) h[j] = 1'($urandom);
    shift_word(1'b1, g, 1'b0);
    do_commit();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL par_good_err got=%b exp=0", cfg_err); end
    shift_word(1'b1, h, 1'b1);
    lut_in = K'($urandom);
    do_commit();
    total++; if (cfg_parity_err !== 1'b1) begin bad++; $display("FAIL par_bad_perr got=%b exp=1", cfg_parity_err); end
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL par_bad_err got=%b exp=1", cfg_err); end
    total++; if (cfg_full !== 1'b1) begin bad++; $display("FAIL par_bad_full got=%b exp=1", cfg_full); end
    total++; if (lut_out !== g[lut_in]) begin bad++; $display("FAIL par_bad_lut in=%0d got=%b exp=%b", lut_in, lut_out, g[lut_in]); end
`else
    total++; if (cfg_parity_err !== 1'b0) begin bad++; $display("FAIL par_tied got=%b exp=0", cfg_parity_err); end
`endif
  endtask

  task automatic test_reset_midshift();
    bit r[TBL];
    bit seq[$];
    for (int i = 0; i < 30; i++) shift_bit(1'($urandom));
    pReset = 1'b1; cfg_en = 1'b1; ccff_head = 1'b1;
    tick();
    pReset = 1'b0; cfg_en = 1'b0;
    total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL mid_tail got=%b exp=0", ccff_tail); end
    total++; if (lut_out !== 1'b0) begin bad++; $display("FAIL mid_lut got=%b exp=0", lut_out); end
    total++; if (lut_frac_out !== 2'b00) begin bad++; $display("FAIL mid_frac got=%b exp=00", lut_frac_out); end
    total++; if (cfg_full !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", cfg_full); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", cfg_err); end
    foreach (r[j]) r[j] = 1'($urandom);
    build_seq(1'b0, r, 1'b0, seq);
    foreach (seq[i]) begin
      shift_bit(seq[i]);
      total++; if (cfg_full !== (i + 1 == L)) begin bad++; $display("FAIL mid_count n=%0d got=%b exp=%b", i + 1, cfg_full, (i + 1 == L)); end
    end
    lut_in = K'($urandom);
    do_commit();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL mid_commit_err got=%b exp=0", cfg_err); end
    total++; if (lut_out !== r[lut_in]) begin bad++; $display("FAIL mid_commit_lut in=%0d got=%b exp=%b", lut_in, lut_out, r[lut_in]); end
    total++; if (lut_frac_out !== 2'b00) begin bad++; $display("FAIL mid_commit_frac got=%b exp=00", lut_frac_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      pReset     = ($urandom_range(0, 199) == 0);
      cfg_en     = ($urandom_range(0, 7) != 0);
      cfg_commit = ($urandom_range(0, 29) == 0) || (m_cnt >= L && $urandom_range(0, 3) == 0);
      ccff_head  = 1'($urandom);
      lut_in     = K'($urandom);
      tick();
      total++; if (ccff_tail !== m_bit(L - 1)) begin bad++; $display("FAIL rnd_tail cyc=%0d got=%b exp=%b", i, ccff_tail, m_bit(L - 1)); end
      total++; if (lut_out !== exp_lut(lut_in)) begin bad++; $display("FAIL rnd_lut cyc=%0d got=%b exp=%b", i, lut_out, exp_lut(lut_in)); end
      total++; if (lut_frac_out !== exp_frac(lut_in)) begin bad++; $display("FAIL rnd_frac cyc=%0d got=%b exp=%b", i, lut_frac_out, exp_frac(lut_in)); end
      total++; if (cfg_full !== (m_cnt >= L)) begin bad++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", i, cfg_full, (m_cnt >= L)); end
      total++; if (cfg_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, cfg_err, m_err); end
      total++; if (cfg_parity_err !== m_perr) begin bad++; $display("FAIL rnd_perr cyc=%0d got=%b exp=%b", i, cfg_parity_err, m_perr); end
    end
    pReset = 1'b0; cfg_en = 1'b0; cfg_commit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_and_table();
    test_partial_commit();
    test_shadow_isolation();
    test_commit_priority();
    test_overshift();
    test_parity();
    test_reset_midshift();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
